ram_port_arbiter: RTL and testbench

- Shares one Single_Port_RAM instance between two requesters, A and B. The RAM has 64 x 8 storage, a separate read address and write address, and a registered read with 1-cycle latency.
- Each cycle the arbiter grants at most one operation, either a read or a write.
- Arbitration is round-robin, with an optional bounded burst lock. The arbiter returns read data to the requester that issued the read.
- The block sits between the client logic and the RAM and drives all RAM input ports.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_port_arbiter_rr_arb2.sv | 25 ++
 rtl/ram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

  // Ownership state of the shared RAM port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  // Requester indices; also the bit positions in the packed grant/request vectors.
  localparam int REQ_A  = 0;
  localparam int REQ_B  = 1;

  // Width of the burst counter; supports MAX_BURST up to 15.
  localparam int BCNT_W = 4;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin picker with an optional forced owner.
// When the forced owner is requesting, it alone is granted.
// Otherwise a single requester is granted.
// On a tie, the side that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_idx,
  output logic [1:0] gnt
);

  // One-hot pick; the owner only dominates while it is still requesting.
  always_comb begin
    gnt = 2'b00;
    if (force_en && req[force_idx]) begin
      gnt[force_idx] = 1'b1;
    end else if (req == 2'b11) begin
      gnt[~last] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one registered-read RAM between requesters A and B.
// At most one operation is granted per cycle.
// Arbitration is round-robin with a bounded lock (burst).
// Read data is routed back to the requester that issued the read.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_w,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);
  localparam logic [BCNT_W-1:0] ONE_B = BCNT_W'(1);

  arb_state_t          state_reg, state_next;
  logic                last_reg, last_next;
  logic [BCNT_W-1:0]   bcnt_reg, bcnt_next;
  logic [BCNT_W-1:0]   bcnt_inc;

  logic [1:0]          req_vec, we_vec, pick, gnt_vec, rd_gnt, rvalid_vec;
  logic                force_en, force_idx, any_gnt, sel_b;
  logic                g_we, g_lock;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [DATA_WIDTH-1:0] rdata_vec [2];

  assign req_vec   = {b_req, a_req};
  assign we_vec    = {b_we, a_we};
  assign force_en  = (state_reg != IDLE);
  assign force_idx = (state_reg == OWN_B);

  rr_arb2 u_pick (
    .req       (req_vec),
    .last      (last_reg),
    .force_en  (force_en),
    .force_idx (force_idx),
    .gnt       (pick)
  );

  // Grants are suppressed for the whole reset cycle so the RAM is never written then.
  assign gnt_vec = rst ? 2'b00 : pick;
  assign a_gnt   = gnt_vec[REQ_A];
  assign b_gnt   = gnt_vec[REQ_B];
  assign any_gnt = |gnt_vec;
  assign sel_b   = gnt_vec[REQ_B];

  assign g_we    = sel_b ? b_we    : a_we;
  assign g_lock  = sel_b ? b_lock  : a_lock;
  assign g_addr  = sel_b ? b_addr  : a_addr;
  assign g_wdata = sel_b ? b_wdata : a_wdata;

  // RAM inputs idle at zero unless the matching operation is granted.
  assign ram_w          = any_gnt & g_we;
  assign ram_write_addr = (any_gnt &  g_we) ? g_addr : '0;
  assign ram_read_addr  = (any_gnt & ~g_we) ? g_addr : '0;
  assign ram_data       = any_gnt ? g_wdata : '0;

  // Next ownership, priority pointer and burst count from this cycle's grant.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    bcnt_next  = bcnt_reg;
    bcnt_inc   = bcnt_reg + ONE_B;
    if (any_gnt) begin
      last_next = sel_b;
      if (force_en && (sel_b == force_idx)) begin
        // Continuing a locked burst; the owner keeps `last`, so the other side wins after a forced exit.
        if (!g_lock || (bcnt_inc >= MAX_B)) begin
          state_next = IDLE;
          bcnt_next  = '0;
        end else begin
          bcnt_next  = bcnt_inc;
        end
      end else if (g_lock && (MAX_B > ONE_B)) begin
        state_next = sel_b ? OWN_B : OWN_A;
        bcnt_next  = ONE_B;
      end else begin
        state_next = IDLE;
        bcnt_next  = '0;
      end
    end else if (force_en) begin
      // Owner stopped requesting and nobody else was granted.
      state_next = IDLE;
      bcnt_next  = '0;
    end
  end

  // Arbitration state registers; `last` resets to B so A wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  assign rd_gnt = gnt_vec & ~we_vec;

  // Per-requester read return path: one valid cycle after the grant, data then held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      logic                  pend_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;

      // Track an outstanding read and remember the last returned word.
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg  <= 1'b0;
          rdata_reg <= '0;
        end else begin
          pend_reg  <= rd_gnt[gi];
          if (rvalid_vec[gi]) begin
            rdata_reg <= ram_q;
          end
        end
      end

      // Reset in the return cycle cancels the return.
      assign rvalid_vec[gi] = pend_reg & ~rst;
      assign rdata_vec[gi]  = rvalid_vec[gi] ? ram_q : rdata_reg;
    end
  endgenerate

  assign a_rvalid = rvalid_vec[REQ_A];
  assign b_rvalid = rvalid_vec[REQ_B];
  assign a_rdata  = rdata_vec[REQ_A];
  assign b_rdata  = rdata_vec[REQ_B];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM plus a reference model of the arbitration rules.
module tb_ram_port_arbiter;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int MAXB = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 0, a_we = 0, a_lock = 0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 0, b_we = 0, b_lock = 0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [DW-1:0] ram_data, ram_q;
  logic [AW-1:0] ram_read_addr, ram_write_addr;
  logic          ram_w;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_w(ram_w), .ram_q(ram_q)
  );

  // Single-port RAM stand-in: registered read, write on the same edge.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_w) ram_mem[ram_write_addr] <= ram_data;
    ram_q <= ram_mem[ram_read_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending operations per requester (0 = A, 1 = B), held until granted.
  bit p_req [2];
  bit p_we  [2];
  bit p_lock[2];
  int p_addr[2];
  int p_wd  [2];

  // Reference model state.
  int own  = -1;   // locked owner, -1 none
  int run  = 0;    // grants so far in the locked run
  int prio = 0;    // side that wins the next contest
  int hold [2] = '{0, 0};
  bit pend_rv [2];
  int pend_val[2];
  int ref_mem [DEPTH];
  bit written [DEPTH];
  int last_g = -1;

  task automatic set_op(input int x, input bit we, input bit lock, input int addr, input int wd);
    p_req[x] = 1; p_we[x] = we; p_lock[x] = lock; p_addr[x] = addr; p_wd[x] = wd;
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model.
  task automatic run_cycle();
    int g, ea;
    bit ew, erv[2];
    int erd[2];
    a_req = p_req[0]; a_we = p_we[0]; a_lock = p_lock[0];
    a_addr = AW'(p_addr[0]); a_wdata = DW'(p_wd[0]);
    b_req = p_req[1]; b_we = p_we[1]; b_lock = p_lock[1];
    b_addr = AW'(p_addr[1]); b_wdata = DW'(p_wd[1]);
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (own >= 0 && p_req[own]) g = own;
      else if (p_req[0] && p_req[1]) g = prio;
      else if (p_req[0]) g = 0;
      else if (p_req[1]) g = 1;
    end
    check_val("a_gnt", a_gnt, g == 0);
    check_val("b_gnt", b_gnt, g == 1);
    ew = (g >= 0) && p_we[g];
    ea = (g >= 0) ? p_addr[g] % DEPTH : 0;
    check_val("ram_w", ram_w, ew);
    check_val("ram_write_addr", ram_write_addr, ew ? ea : 0);
    check_val("ram_read_addr", ram_read_addr, (g >= 0 && !ew) ? ea : 0);
    check_val("ram_data", ram_data, (g >= 0) ? p_wd[g] % 256 : 0);
    for (int x = 0; x < 2; x++) begin
      erv[x] = pend_rv[x] && !rst;
      erd[x] = erv[x] ? pend_val[x] : hold[x];
    end
    check_val("a_rvalid", a_rvalid, erv[0]);
    check_val("b_rvalid", b_rvalid, erv[1]);
    if (!rst) begin
      check_val("a_rdata", a_rdata, erd[0]);
      check_val("b_rdata", b_rdata, erd[1]);
    end
    last_g = g;
    @(posedge clk);
    if (rst) begin
      own = -1; run = 0; prio = 0;
      for (int x = 0; x < 2; x++) begin hold[x] = 0; pend_rv[x] = 0; end
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (erv[x]) hold[x] = erd[x];
        pend_rv[x] = 0;
      end
      if (g >= 0) begin
        prio = 1 - g;
        if (!p_we[g]) begin
          pend_rv[g] = 1; pend_val[g] = ref_mem[ea];
        end else begin
          ref_mem[ea] = p_wd[g] % 256; written[ea] = 1;
        end
        if (own == g) begin
          run++;
          if (!p_lock[g] || run >= MAXB) own = -1;
        end else begin
          own = -1;
          if (p_lock[g] && MAXB > 1) begin own = g; run = 1; end
        end
        p_req[g] = 0;
      end else begin
        own = -1;
      end
    end
    #1;
  endtask

  task automatic rand_op(input int x, input bit lock);
    int ad;
    bit we;
    ad = $urandom_range(0, DEPTH - 1);
    we = $urandom_range(0, 1) == 1;
    if (!written[ad]) we = 1;
    set_op(x, we, lock, ad, $urandom_range(0, 255));
  endtask

  initial begin
    int na, seq_ok;
    #1;
    // Reset for two cycles.
    run_cycle(); run_cycle();
    rst = 0;

    // Simultaneous writes, A first, then read both back.
    set_op(0, 1, 0, 3, 8'h5A); set_op(1, 1, 0, 4, 8'h3C);
    run_cycle(); check_val("first_contest_a", last_g, 0);
    run_cycle(); check_val("second_b", last_g, 1);
    set_op(0, 0, 0, 3, 0); set_op(1, 0, 0, 4, 0);
    run_cycle(); run_cycle(); run_cycle();
    check_val("b_read_4", b_rdata, 8'h3C);
    check_val("a_read_3_held", a_rdata, 8'h5A);

    // Continuous unlocked requests alternate.
    seq_ok = 1;
    for (int i = 0; i < 8; i++) begin
      int prev;
      prev = last_g;
      if (!p_req[0]) rand_op(0, 0);
      if (!p_req[1]) rand_op(1, 0);
      run_cycle();
      if (i > 0 && (last_g == prev || last_g < 0)) seq_ok = 0;
    end
    check_val("alternate", seq_ok, 1);
    while (p_req[0] || p_req[1]) run_cycle();

    // Locked burst: arrange for A to hold priority, then lock against B.
    set_op(1, 1, 0, 20, 1); run_cycle();
    set_op(0, 1, 1, 21, 2); set_op(1, 1, 0, 22, 3);
    na = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      if (last_g == 0) na++;
      set_op(0, 1, 1, 21 + i, i);
    end
    check_val("burst_a_count", na, MAXB);
    run_cycle(); check_val("burst_then_b", last_g, 1);
    p_req[0] = 0; run_cycle();

    // Write by A, read by B the next cycle.
    set_op(0, 1, 0, 10, 8'h11); run_cycle();
    set_op(1, 0, 0, 10, 0); run_cycle(); run_cycle();
    check_val("raw_b_rdata", b_rdata, 8'h11);

    // Reset in the return cycle of A's read.
    set_op(0, 0, 0, 10, 0); run_cycle();
    rst = 1; set_op(1, 1, 0, 30, 9); run_cycle();
    rst = 0;
    set_op(0, 1, 0, 31, 5);
    run_cycle(); check_val("post_rst_a", last_g, 0);
    run_cycle();

    // Address wrap: 64 aliases to 0.
    set_op(0, 1, 0, 63, 8'h7F); run_cycle();
    set_op(0, 1, 0, 64, 8'h7F); run_cycle();
    set_op(0, 0, 0, 0, 0); run_cycle(); run_cycle();
    check_val("wrap_read0", a_rdata, 8'h7F);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      for (int x = 0; x < 2; x++)
        if (!p_req[x] && $urandom_range(0, 3) != 0) rand_op(x, $urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 99) == 0);
      run_cycle();
    end
    rst = 0;
    run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
